// File: rtl/mem_access_ctrl.sv
// Memory-access stage controller: classifies the instruction, issues one data-memory request,
// waits (bounded) for read data and hands a single result to the downstream consumer.
module mem_access_ctrl #(
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        mreq_valid,
    input  logic        mreq_ready,
    output logic        mreq_we,
    output logic [63:0] mreq_addr,
    output logic [63:0] mreq_wdata,
    input  logic        mresp_valid,
    input  logic [63:0] mresp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        busy
);

    localparam int unsigned CntW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TimeoutLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
    typedef enum logic [1:0] {OpNone, OpRead, OpWrite} op_e;

    function automatic op_e op_of(input logic [3:0] ic);
        case (ic)
            4'h5, 4'h9, 4'hB: return OpRead;
            4'h4, 4'hA, 4'h8: return OpWrite;
            default:          return OpNone;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      icode_q, icode_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     valm_q, valm_d;
    logic            err_q, err_d;

    op_e         dec_op;
    logic [63:0] dec_addr;
    logic [63:0] dec_wdata;
    logic        dec_oob;

    always_comb begin
        dec_op    = op_of(icode);
        dec_addr  = '0;
        dec_wdata = '0;
        case (icode)
            4'h5:       dec_addr = valE;
            4'h9, 4'hB: dec_addr = valA;
            4'h4, 4'hA: begin
                dec_addr  = valE;
                dec_wdata = valA;
            end
            4'h8: begin
                dec_addr  = valE;
                dec_wdata = valP;
            end
            default: ;
        endcase
        // Full-width compare so huge addresses never alias into range.
        dec_oob = (dec_addr >= 64'(MEM_WORDS));
    end

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        valm_d  = valm_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    icode_d = icode;
                    addr_d  = dec_addr;
                    wdata_d = dec_wdata;
                    cnt_d   = '0;
                    valm_d  = '0;
                    err_d   = 1'b0;
                    if (dec_op == OpNone) begin
                        state_d = StDone;
                    end else if (dec_oob) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mreq_ready) begin
                    cnt_d   = '0;
                    state_d = (op_of(icode_q) == OpWrite) ? StDone : StWait;
                end
            end
            StWait: begin
                // Data arriving on the final cycle still beats the timeout.
                if (mresp_valid) begin
                    valm_d  = mresp_rdata;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TimeoutLast)) begin
                    valm_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    valm_d  = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            icode_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign mreq_valid = (state_q == StReq);
    assign mreq_we    = mreq_valid & (op_of(icode_q) == OpWrite);
    assign mreq_addr  = mreq_valid ? addr_q : '0;
    assign mreq_wdata = mreq_valid ? wdata_q : '0;
    assign out_valid  = (state_q == StDone);
    assign valM       = valm_q;
    assign dmem_error = err_q;

endmodule
